// File: rtl/div_pkg.sv
// ============================================================================
// Module      : div_pkg
// Description : Shared types and constants for the iterative divide sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package div_pkg;

    localparam int          DIV_WIDTH  = 32;
    localparam int          DIV_CNT_W  = 6;
    localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

endpackage

`default_nettype wire

// File: rtl/div_step.sv
// ============================================================================
// Module      : div_step
// Description : One combinational restoring-division iteration (one quotient bit).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             dvd_msb_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_o
);

    // One extra bit so a shifted remainder of 2^WIDTH or more still compares correctly.
    logic [WIDTH:0] w_shifted;

    always_comb begin
        w_shifted = {rem_i, dvd_msb_i};
        q_o       = (w_shifted >= {1'b0, divisor_i});
        rem_o     = q_o ? WIDTH'(w_shifted - {1'b0, divisor_i}) : w_shifted[WIDTH-1:0];
    end

endmodule

`default_nettype wire

// File: rtl/div_sequencer.sv
// ============================================================================
// Module      : div_sequencer
// Description : Multi-cycle restoring radix-2 DIV/DIVU controller for the E stage.
//               Optional macro DIV_SEQ_EARLY_OUT_EN skips iterations when the
//               quotient is trivially zero or the divisor is zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_sequencer
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = DIV_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cancel_i,
    output logic             stall_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             div_zero_o
);

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] bmag_q, bmag_d;
    logic [WIDTH-1:0] aorig_q, aorig_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             bzero_q, bzero_d;
    logic             dz_q, dz_d;

    logic [WIDTH-1:0] w_amag, w_bmag, w_step_rem;
    logic             w_step_q, w_early;

    assign w_amag = (signed_i && a_i[WIDTH-1]) ? -a_i : a_i;
    assign w_bmag = (signed_i && b_i[WIDTH-1]) ? -b_i : b_i;

`ifdef DIV_SEQ_EARLY_OUT_EN
    assign w_early = (b_i == '0) || (w_amag < w_bmag);
`else
    assign w_early = 1'b0;
`endif

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q),
        .dvd_msb_i (dvd_q[WIDTH-1]),
        .divisor_i (bmag_q),
        .rem_o     (w_step_rem),
        .q_o       (w_step_q)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        bmag_d  = bmag_q;
        aorig_d = aorig_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        bzero_d = bzero_q;
        dz_d    = dz_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    bmag_d  = w_bmag;
                    aorig_d = a_i;
                    qneg_d  = signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                    rneg_d  = signed_i & a_i[WIDTH-1];
                    bzero_d = (b_i == '0);
                    cnt_d   = '0;
                    if (w_early) begin
                        // Quotient is zero: the remainder is the dividend magnitude.
                        rem_d   = w_amag;
                        dvd_d   = '0;
                        state_d = FIX;
                    end else begin
                        rem_d   = '0;
                        dvd_d   = w_amag;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (cancel_i) begin
                    state_d = IDLE;
                end else begin
                    rem_d = w_step_rem;
                    dvd_d = {dvd_q[WIDTH-2:0], w_step_q};
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH-1)) begin
                        state_d = FIX;
                    end
                end
            end
            FIX: begin
                if (cancel_i) begin
                    state_d = IDLE;
                end else begin
                    if (bzero_q) begin
                        lo_d = '1;
                        hi_d = aorig_q;
                    end else begin
                        lo_d = qneg_q ? -dvd_q : dvd_q;
                        hi_d = rneg_q ? -rem_q : rem_q;
                    end
                    dz_d    = bzero_q;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            bmag_q  <= '0;
            aorig_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            bzero_q <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            bmag_q  <= bmag_d;
            aorig_q <= aorig_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            bzero_q <= bzero_d;
            dz_q    <= dz_d;
        end
    end

    // DONE does not stall so the divide instruction retires with its HI/LO write.
    assign stall_o    = ((state_q == IDLE) && start_i) || (state_q == BUSY) || (state_q == FIX);
    assign done_o     = (state_q == DONE);
    assign hi_o       = hi_q;
    assign lo_o       = lo_q;
    assign div_zero_o = dz_q;

endmodule

`default_nettype wire

// File: tb/tb_div_sequencer.sv
// ============================================================================
// Module      : tb_div_sequencer
// Description : Directed self-checking bench for div_sequencer (honours
//               DIV_SEQ_EARLY_OUT_EN when defined).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div_sequencer;

`ifdef DIV_SEQ_EARLY_OUT_EN
    localparam bit C_EARLY = 1'b1;
`else
    localparam bit C_EARLY = 1'b0;
`endif

    logic        clk      = 1'b0;
    logic        rst      = 1'b0;
    logic        start_i  = 1'b0;
    logic        signed_i = 1'b0;
    logic        cancel_i = 1'b0;
    logic [31:0] a_i      = '0;
    logic [31:0] b_i      = '0;
    logic        stall_o;
    logic        done_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        div_zero_o;

    int total = 0;
    int bad   = 0;

    div_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .signed_i   (signed_i),
        .a_i        (a_i),
        .b_i        (b_i),
        .cancel_i   (cancel_i),
        .stall_o    (stall_o),
        .done_o     (done_o),
        .hi_o       (hi_o),
        .lo_o       (lo_o),
        .div_zero_o (div_zero_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        logic [31:0] ma, mb;
        ma = (sgn && a[31]) ? -a : a;
        mb = (sgn && b[31]) ? -b : b;
        if (C_EARLY && ((b == 32'd0) || (ma < mb))) return 2;
        return 34;
    endfunction

    // Called at a negedge with the DUT idle; returns just after the accepting edge.
    task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                          input logic with_cancel);
        a_i      = a;
        b_i      = b;
        signed_i = sgn;
        start_i  = 1'b1;
        cancel_i = with_cancel;
        #1;
        check("stall_req", stall_o, 1);
        @(posedge clk);
        #1;
        start_i  = 1'b0;
        cancel_i = 1'b0;
    endtask

    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                           input logic [31:0] elo, input logic [31:0] ehi, input logic edz,
                           input logic noise, input logic with_cancel);
        int   lat;
        int   n;
        int   stall_bad;
        logic got;
        lat       = exp_lat(a, b, sgn);
        n         = 0;
        got       = 1'b0;
        stall_bad = 0;
        @(negedge clk);
        launch(a, b, sgn, with_cancel);
        while (!got && n < 60) begin
            @(negedge clk);
            n++;
            if (done_o) begin
                got = 1'b1;
            end else begin
                if (!stall_o) stall_bad++;
                if (noise && n == 5) begin
                    start_i = 1'b1;
                    a_i     = 32'd50;
                    b_i     = 32'd5;
                end
                if (n == 6) start_i = 1'b0;
            end
        end
        check("done_seen", got, 1);
        check("latency", 32'(n), 32'(lat));
        check("stall_busy", 32'(stall_bad), 0);
        check("lo", lo_o, elo);
        check("hi", hi_o, ehi);
        check("div_zero", div_zero_o, edz);
        check("stall_done", stall_o, 0);
        if (noise) start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        @(negedge clk);
        check("done_pulse", done_o, 0);
        check("stall_after", stall_o, 0);
        check("lo_hold", lo_o, elo);
        check("hi_hold", hi_o, ehi);
    endtask

    task automatic reset_mid(input string tag, input int cycles);
        @(negedge clk);
        launch(32'd100, 32'd7, 1'b0, 1'b0);
        repeat (cycles) @(negedge clk);
        check({tag, "_stall_pre"}, stall_o, 1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check({tag, "_lo"}, lo_o, 0);
        check({tag, "_hi"}, hi_o, 0);
        check({tag, "_dz"}, div_zero_o, 0);
        check({tag, "_done"}, done_o, 0);
        check({tag, "_stall"}, stall_o, 0);
    endtask

    initial begin
        int dseen;

        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("rst_lo", lo_o, 0);
        check("rst_hi", hi_o, 0);
        check("rst_done", done_o, 0);
        check("rst_dz", div_zero_o, 0);
        check("rst_stall", stall_o, 0);

        run_div(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 1'b1, 1'b0);
        run_div(32'hFFFF_FFF9, 32'h2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'h0, 1'b0, 1'b0, 1'b0);
        run_div(32'hFFFF_FFF0, 32'h0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF0, 1'b1, 1'b0, 1'b0);
        run_div(32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0, 1'b0, 1'b0);
        run_div(32'hFFFF_FFFF, 32'd2, 1'b0, 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b1, 1'b0);
        run_div(32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0, 1'b0, 1'b0);
        run_div(32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0, 1'b0, 1'b0);

        // Abort in the tenth BUSY cycle; the previous 9/3 result must survive.
        @(negedge clk);
        launch(32'd1000, 32'd3, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        check("cancel_cyc_stall", stall_o, 1);
        cancel_i = 1'b1;
        @(posedge clk);
        #1;
        cancel_i = 1'b0;
        @(negedge clk);
        check("cancel_stall", stall_o, 0);
        check("cancel_done", done_o, 0);
        check("cancel_lo", lo_o, 32'd3);
        check("cancel_hi", hi_o, 32'd0);
        dseen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done_o) dseen++;
        end
        check("cancel_no_done", 32'(dseen), 0);

        // Start held together with cancel in IDLE: the start must win.
        run_div(32'd1000, 32'd3, 1'b0, 32'd333, 32'd1, 1'b0, 1'b0, 1'b1);
        run_div(32'd5, 32'd9, 1'b0, 32'd0, 32'd5, 1'b0, 1'b0, 1'b0);

        run_div(32'hFFFF_FFF0, 32'h0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF0, 1'b1, 1'b0, 1'b0);
        reset_mid("rst_busy", 5);
        run_div(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 1'b0, 1'b0);
        reset_mid("rst_fix", 33);
        run_div(32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
